trap_sequencer: RTL and testbench

- Sequences asynchronous trap entry (machine external, software and timer interrupts) for the RV32 core.
- Sits beside the CSR stage. Takes the mip/mie/mstatus.mie/mode state it exports, plus raw interrupt lines.
- Arbitrates sources by fixed priority, stalls the front end, waits for the pipeline to drain, then hands one registered trap request to the CSR stage with a valid/ready handshake.
- Replaces ad-hoc stall/interrupt_ready gating inside the CSR stage.

---
 rtl/trap_pkg.sv | 25 ++
 rtl/trap_sequencer_if.sv | 11 +
 rtl/trap_irq_select.sv | 41 ++++
 rtl/trap_sequencer.sv | 119 +++++++++++
 tb/tb_trap_sequencer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the trap sequencer: FSM states, privilege modes,
// interrupt bit positions and the mcause values they produce.
package trap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_COOLDOWN = 2'd3
   } trap_state_t;

   localparam logic [1:0] MODE_MACHINE    = 2'd3;
   localparam logic [1:0] MODE_SUPERVISOR = 2'd1;
   localparam logic [1:0] MODE_USER       = 2'd0;

   localparam int IRQ_MEI = 11;
   localparam int IRQ_MTI = 7;
   localparam int IRQ_MSI = 3;

   // Interrupt causes carry the interrupt flag in bit 31 and the mip index below it.
   localparam logic [31:0] CAUSE_MEI = 32'h8000_0000 | 32'(IRQ_MEI);
   localparam logic [31:0] CAUSE_MSI = 32'h8000_0000 | 32'(IRQ_MSI);
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0000 | 32'(IRQ_MTI);

endpackage

// File: rtl/trap_sequencer_if.sv
// Trap request handshake between the sequencer (master) and the CSR stage (slave).
interface trap_sequencer_if #(
   parameter int CAUSE_W = 32
);
   logic               trap_valid;
   logic [CAUSE_W-1:0] trap_cause;
   logic               trap_ready;

   modport master (output trap_valid, output trap_cause, input trap_ready);
   modport slave  (input trap_valid, input trap_cause, output trap_ready);
endinterface

// File: rtl/trap_irq_select.sv
// Combinational eligibility check and fixed-priority (MEI > MSI > MTI) cause select.
module trap_irq_select
   import trap_pkg::*;
#(
   parameter int CAUSE_W = 32
) (
   input  logic               irq_mei,
   input  logic               irq_msi,
   input  logic               irq_mti,
   input  logic               mie_meie,
   input  logic               mie_msie,
   input  logic               mie_mtie,
   input  logic               mstatus_mie,
   input  logic               mideleg_mtie,
   input  logic [1:0]         mode,
   output logic               any_eligible,
   output logic [CAUSE_W-1:0] cause
);

   logic global_en;
   logic elig_mei;
   logic elig_msi;
   logic elig_mti;

   // Below machine mode, M-level interrupts are taken regardless of mstatus.MIE.
   assign global_en = (mode < MODE_MACHINE) | mstatus_mie;

   assign elig_mei = irq_mei & mie_meie & global_en;
   assign elig_msi = irq_msi & mie_msie & global_en;
   assign elig_mti = irq_mti & mie_mtie & global_en & ~mideleg_mtie;

   assign any_eligible = elig_mei | elig_msi | elig_mti;

   always_comb begin
      cause = '0;
      if (elig_mei)      cause = CAUSE_W'(CAUSE_MEI);
      else if (elig_msi) cause = CAUSE_W'(CAUSE_MSI);
      else if (elig_mti) cause = CAUSE_W'(CAUSE_MTI);
   end

endmodule

// File: rtl/trap_sequencer.sv
// Asynchronous trap entry sequencer: arbitrate, stall and drain, then issue one trap.
// Optional TRAP_SEQ_STATS_EN adds the trap_count handshake counter.
//
// state       | meaning
// ST_IDLE     | no stall, waiting for an eligible interrupt
// ST_DRAIN    | front end stalled, waiting for pipe_empty without wb hazard
// ST_ISSUE    | trap_valid held with latched cause until trap_ready
// ST_COOLDOWN | one stalled cycle so the CSR stage can clear mstatus.MIE
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 15,
   parameter int CAUSE_W       = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      irq_mei,
   input  logic                      irq_msi,
   input  logic                      irq_mti,
   input  logic                      mie_meie,
   input  logic                      mie_msie,
   input  logic                      mie_mtie,
   input  logic                      mstatus_mie,
   input  logic                      mideleg_mtie,
   input  logic [1:0]                mode,
   input  logic                      pipe_empty,
   input  logic                      wb_branch_hazard,
   output logic                      stall_front,
   trap_sequencer_if.master          trap_bus,
   output logic                      drain_timeout
`ifdef TRAP_SEQ_STATS_EN
   ,
   output logic [31:0]               trap_count
`endif
);

   trap_state_t        state;
   logic [7:0]         drain_cnt;
   logic               any_eligible;
   logic [CAUSE_W-1:0] sel_cause;

   trap_irq_select #(
      .CAUSE_W (CAUSE_W)
   ) u_irq_select (
      .irq_mei      (irq_mei),
      .irq_msi      (irq_msi),
      .irq_mti      (irq_mti),
      .mie_meie     (mie_meie),
      .mie_msie     (mie_msie),
      .mie_mtie     (mie_mtie),
      .mstatus_mie  (mstatus_mie),
      .mideleg_mtie (mideleg_mtie),
      .mode         (mode),
      .any_eligible (any_eligible),
      .cause        (sel_cause)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= ST_IDLE;
         stall_front         <= 1'b0;
         trap_bus.trap_valid <= 1'b0;
         trap_bus.trap_cause <= '0;
         drain_timeout       <= 1'b0;
         drain_cnt           <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_eligible) begin
                  state       <= ST_DRAIN;
                  stall_front <= 1'b1;
                  drain_cnt   <= '0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 8'(DRAIN_TIMEOUT)) drain_timeout <= 1'b1;
               if (drain_cnt != 8'hFF) drain_cnt <= drain_cnt + 8'd1;
               if (!any_eligible) begin
                  state       <= ST_IDLE;
                  stall_front <= 1'b0;
               end else if (wb_branch_hazard) begin
                  drain_cnt <= '0;
               end else if (pipe_empty) begin
                  state               <= ST_ISSUE;
                  trap_bus.trap_valid <= 1'b1;
                  trap_bus.trap_cause <= sel_cause;
               end
            end
            // Committed: source withdrawal and wb hazards no longer matter here.
            ST_ISSUE: begin
               if (trap_bus.trap_ready) begin
                  state               <= ST_COOLDOWN;
                  trap_bus.trap_valid <= 1'b0;
               end
            end
            ST_COOLDOWN: begin
               state       <= ST_IDLE;
               stall_front <= 1'b0;
            end
            default: begin
               state               <= ST_IDLE;
               stall_front         <= 1'b0;
               trap_bus.trap_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef TRAP_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_count <= '0;
      end else if (state == ST_ISSUE && trap_bus.trap_ready) begin
         trap_count <= trap_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized
// source/enable/mode combinations checked against a priority model.
module tb_trap_sequencer;

   localparam logic [31:0] C_MEI = 32'h8000000B;
   localparam logic [31:0] C_MSI = 32'h80000003;
   localparam logic [31:0] C_MTI = 32'h80000007;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       irq_mei, irq_msi, irq_mti;
   logic       mie_meie, mie_msie, mie_mtie;
   logic       mstatus_mie, mideleg_mtie;
   logic [1:0] mode;
   logic       pipe_empty, wb_branch_hazard;
   logic       stall_front, drain_timeout;
`ifdef TRAP_SEQ_STATS_EN
   logic [31:0] trap_count;
`endif

   int checks = 0;
   int failures = 0;
   int exp_count = 0;

   trap_sequencer_if #(.CAUSE_W(32)) trap_bus ();

   trap_sequencer #(
      .DRAIN_TIMEOUT (15),
      .CAUSE_W       (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .irq_mei          (irq_mei),
      .irq_msi          (irq_msi),
      .irq_mti          (irq_mti),
      .mie_meie         (mie_meie),
      .mie_msie         (mie_msie),
      .mie_mtie         (mie_mtie),
      .mstatus_mie      (mstatus_mie),
      .mideleg_mtie     (mideleg_mtie),
      .mode             (mode),
      .pipe_empty       (pipe_empty),
      .wb_branch_hazard (wb_branch_hazard),
      .stall_front      (stall_front),
      .trap_bus         (trap_bus),
      .drain_timeout    (drain_timeout)
`ifdef TRAP_SEQ_STATS_EN
      ,
      .trap_count       (trap_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference: a source is takeable when pending, enabled and globally allowed;
   // the first takeable one in MEI, MSI, MTI order wins.
   function automatic bit model_take(input bit mei, input bit msi, input bit mti,
                                     input bit meie, input bit msie, input bit mtie,
                                     input bit smie, input bit deleg, input int md,
                                     output logic [31:0] cause);
      bit          gate;
      bit          elig [3];
      logic [31:0] codes [3];
      gate = (md < 3) || smie;
      elig[0] = mei && meie && gate;
      elig[1] = msi && msie && gate;
      elig[2] = mti && mtie && gate && !deleg;
      codes[0] = C_MEI;
      codes[1] = C_MSI;
      codes[2] = C_MTI;
      cause = '0;
      for (int i = 0; i < 3; i++) begin
         if (elig[i]) begin
            cause = codes[i];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      irq_mei = 0; irq_msi = 0; irq_mti = 0;
      mie_meie = 0; mie_msie = 0; mie_mtie = 0;
      mstatus_mie = 0; mideleg_mtie = 0; mode = 2'd3;
      pipe_empty = 1; wb_branch_hazard = 0;
      trap_bus.trap_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      exp_count = 0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({stall_front, trap_bus.trap_valid, drain_timeout} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs stall/valid/timeout=%b expected 000",
                  {stall_front, trap_bus.trap_valid, drain_timeout});
      end
      checks++;
      if (trap_bus.trap_cause !== 32'h0) begin
         failures++;
         $display("FAIL reset_cause got=%h expected 00000000", trap_bus.trap_cause);
      end
   endtask

   task automatic test_latency();
      irq_mti = 1; mie_mtie = 1; mstatus_mie = 1; mode = 2'd3;
      tick();
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b10) begin
         failures++;
         $display("FAIL lat_n1 stall/valid=%b expected 10", {stall_front, trap_bus.trap_valid});
      end
      tick();
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b11 || trap_bus.trap_cause !== C_MTI) begin
         failures++;
         $display("FAIL lat_n2 stall/valid=%b cause=%h expected 11 %h",
                  {stall_front, trap_bus.trap_valid}, trap_bus.trap_cause, C_MTI);
      end
      tick();
      exp_count++;
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b10) begin
         failures++;
         $display("FAIL lat_n3 stall/valid=%b expected 10", {stall_front, trap_bus.trap_valid});
      end
      irq_mti = 0;
      tick();
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b00) begin
         failures++;
         $display("FAIL lat_n4 stall/valid=%b expected 00", {stall_front, trap_bus.trap_valid});
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_priority();
      logic [31:0] exp_cause [2];
      exp_cause[0] = C_MEI;
      exp_cause[1] = C_MSI;
      for (int k = 0; k < 2; k++) begin
         irq_mei = 1; irq_msi = 1; irq_mti = 1;
         mie_meie = (k == 0); mie_msie = 1; mie_mtie = 1;
         mstatus_mie = 1;
         tick();
         tick();
         checks++;
         if (trap_bus.trap_valid !== 1'b1 || trap_bus.trap_cause !== exp_cause[k]) begin
            failures++;
            $display("FAIL priority_%0d valid=%b cause=%h expected 1 %h",
                     k, trap_bus.trap_valid, trap_bus.trap_cause, exp_cause[k]);
         end
         exp_count++;
         idle_inputs();
         tick();
         tick();
      end
   endtask

   task automatic test_mode_gate();
      bit seen = 0;
      irq_mti = 1; mie_mtie = 1; mstatus_mie = 0; mode = 2'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (stall_front !== 1'b0 || trap_bus.trap_valid !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL mode_gate_m left IDLE with mstatus_mie=0 in M-mode, expected stay idle");
      end
      mode = 2'd0;
      tick();
      tick();
      checks++;
      if (trap_bus.trap_valid !== 1'b1 || trap_bus.trap_cause !== C_MTI) begin
         failures++;
         $display("FAIL mode_gate_u valid=%b cause=%h expected 1 %h",
                  trap_bus.trap_valid, trap_bus.trap_cause, C_MTI);
      end
      exp_count++;
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_random();
      logic [31:0] cause;
      bit          take;
      int          md;
      int          pick;
      for (int t = 0; t < 40; t++) begin
         irq_mei = 1'($urandom_range(0, 1));
         irq_msi = 1'($urandom_range(0, 1));
         irq_mti = 1'($urandom_range(0, 1));
         mie_meie = ($urandom_range(0, 3) != 0);
         mie_msie = ($urandom_range(0, 3) != 0);
         mie_mtie = ($urandom_range(0, 3) != 0);
         mstatus_mie = 1'($urandom_range(0, 1));
         mideleg_mtie = ($urandom_range(0, 3) == 0);
         pick = int'($urandom_range(0, 2));
         md = (pick == 2) ? 3 : pick;
         mode = 2'(md);
         take = model_take(irq_mei, irq_msi, irq_mti, mie_meie, mie_msie, mie_mtie,
                           mstatus_mie, mideleg_mtie, md, cause);
         if (take) begin
            tick();
            checks++;
            if ({stall_front, trap_bus.trap_valid} !== 2'b10) begin
               failures++;
               $display("FAIL rand_%0d_drain stall/valid=%b expected 10",
                        t, {stall_front, trap_bus.trap_valid});
            end
            tick();
            checks++;
            if (trap_bus.trap_valid !== 1'b1 || trap_bus.trap_cause !== cause) begin
               failures++;
               $display("FAIL rand_%0d_issue valid=%b cause=%h expected 1 %h",
                        t, trap_bus.trap_valid, trap_bus.trap_cause, cause);
            end
            tick();
            exp_count++;
            tick();
            checks++;
            if ({stall_front, trap_bus.trap_valid} !== 2'b00) begin
               failures++;
               $display("FAIL rand_%0d_idle stall/valid=%b expected 00",
                        t, {stall_front, trap_bus.trap_valid});
            end
         end else begin
            tick();
            tick();
            checks++;
            if ({stall_front, trap_bus.trap_valid} !== 2'b00) begin
               failures++;
               $display("FAIL rand_%0d_noelig stall/valid=%b expected 00",
                        t, {stall_front, trap_bus.trap_valid});
            end
         end
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_drop_drain();
      bit seen_valid = 0;
      pipe_empty = 0;
      irq_mei = 1; mie_meie = 1; mstatus_mie = 1;
      tick();
      tick();
      tick();
      checks++;
      if (stall_front !== 1'b1) begin
         failures++;
         $display("FAIL drop_drain_stall stall_front=%b expected 1", stall_front);
      end
      irq_mei = 0;
      tick();
      checks++;
      if (stall_front !== 1'b0) begin
         failures++;
         $display("FAIL drop_drain_release stall_front=%b expected 0", stall_front);
      end
      pipe_empty = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (trap_bus.trap_valid !== 1'b0 || stall_front !== 1'b0) seen_valid = 1;
      end
      checks++;
      if (seen_valid) begin
         failures++;
         $display("FAIL drop_drain_quiet activity after withdrawal, expected none");
      end
      idle_inputs();
   endtask

   task automatic test_hold_issue();
      trap_bus.trap_ready = 0;
      irq_msi = 1; mie_msie = 1; mstatus_mie = 1;
      tick();
      tick();
      irq_msi = 0;
      wb_branch_hazard = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({stall_front, trap_bus.trap_valid} !== 2'b11 || trap_bus.trap_cause !== C_MSI) begin
            failures++;
            $display("FAIL hold_issue_%0d stall/valid=%b cause=%h expected 11 %h",
                     i, {stall_front, trap_bus.trap_valid}, trap_bus.trap_cause, C_MSI);
         end
      end
      wb_branch_hazard = 0;
      trap_bus.trap_ready = 1;
      tick();
      exp_count++;
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b10) begin
         failures++;
         $display("FAIL hold_issue_cool stall/valid=%b expected 10",
                  {stall_front, trap_bus.trap_valid});
      end
      tick();
      checks++;
      if (stall_front !== 1'b0) begin
         failures++;
         $display("FAIL hold_issue_idle stall_front=%b expected 0", stall_front);
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      pipe_empty = 0;
      irq_mei = 1; mie_meie = 1; mstatus_mie = 1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      wb_branch_hazard = 1;
      tick();
      wb_branch_hazard = 0;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (drain_timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early drain_timeout=%b expected 0", drain_timeout);
      end
      tick();
      checks++;
      if (drain_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_set drain_timeout=%b expected 1", drain_timeout);
      end
      for (int i = 0; i < 4; i++) tick();
      pipe_empty = 1;
      tick();
      checks++;
      if (trap_bus.trap_valid !== 1'b1 || trap_bus.trap_cause !== C_MEI || drain_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_issue valid=%b cause=%h timeout=%b expected 1 %h 1",
                  trap_bus.trap_valid, trap_bus.trap_cause, drain_timeout, C_MEI);
      end
      irq_mei = 0;
      tick();
      exp_count++;
      tick();
      checks++;
      if (drain_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky drain_timeout=%b expected 1", drain_timeout);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      for (int h = 0; h < 2; h++) begin
         irq_mti = 1; mie_mtie = 1; mstatus_mie = 1;
         tick();
         tick();
         tick();
         exp_count++;
         irq_mti = 0;
         tick();
      end
`ifdef TRAP_SEQ_STATS_EN
      checks++;
      if (trap_count !== 32'(exp_count)) begin
         failures++;
         $display("FAIL stats_count trap_count=%0d expected %0d", trap_count, exp_count);
      end
`endif
      trap_bus.trap_ready = 0;
      irq_mei = 1; mie_meie = 1;
      tick();
      tick();
      checks++;
      if (trap_bus.trap_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre valid=%b expected 1", trap_bus.trap_valid);
      end
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({stall_front, trap_bus.trap_valid} !== 2'b00 || trap_bus.trap_cause !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_async stall/valid=%b cause=%h expected 00 00000000",
                  {stall_front, trap_bus.trap_valid}, trap_bus.trap_cause);
      end
`ifdef TRAP_SEQ_STATS_EN
      checks++;
      if (trap_count !== 32'd0) begin
         failures++;
         $display("FAIL stats_reset trap_count=%0d expected 0", trap_count);
      end
`endif
      idle_inputs();
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_latency();
      test_priority();
      test_mode_gate();
      test_random();
      test_drop_drain();
      test_hold_issue();
      test_timeout();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
